mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder to the control unit's Read/Write strobes. Samples the address
//   (from MAR) and write data (from MDR), and models a 32-bit word RAM with configurable
//   wait states. Returns read data on Mdatain and a one-cycle Done pulse. Sits between
//   MAR/MDR and the MDR input mux; the CU holds its memory-access T-state until Done.
// PARAMETERS
//   DATA_W       32   word width
//   ADDR_W       9    address width (MAR low bits)
//   DEPTH        512  implemented words; must be <= 2**ADDR_W
//   WAIT_STATES  2    extra cycles before the array access; 0..15
// PORTS
//   Clock     in   1       rising-edge clock
//   Reset     in   1       asynchronous, active-high
//   Read      in   1       CU read request, level, held until Done
//   Write     in   1       CU write request, level, held until Done
//   Address   in   ADDR_W  word address from MAR
//   MDatain   in   DATA_W  write data from MDR
//   Mdatain   out  DATA_W  read data to MDR mux (registered)
//   Done      out  1       one-cycle completion pulse
//   Busy      out  1       high from request accept until return to IDLE
//   Err       out  1       one-cycle pulse: illegal request (Read&Write, or Address>=DEPTH)
// BEHAVIOUR
//   Reset: state=IDLE, Mdatain=0, Done=0, Busy=0, Err=0, wait counter=0.
//     RAM contents are not cleared.
//   States: IDLE, WAIT, ACCESS, DONE, HOLD.
//   IDLE: on an edge with Read^Write=1, latch op/Address/MDatain.
//     Go to WAIT (cnt=WAIT_STATES-1), or to ACCESS if WAIT_STATES=0. Busy=1 from next cycle.
//   IDLE with Read&Write both 1: no access; go to DONE with Err=1 in the same DONE cycle.
//   WAIT: decrement cnt; at cnt=0 go to ACCESS. Latched values are used; input changes are ignored.
//   ACCESS, one edge:
//     read:  Mdatain <= RAM[addr].
//     write: RAM[addr] <= data; Mdatain unchanged.
//     addr>=DEPTH: no RAM op, Mdatain <= 0 on a read, Err=1 in DONE.
//     Next state: DONE.
//   DONE: Done=1 (and Err if flagged) for exactly one cycle; then go to HOLD.
//   HOLD: Busy=1; stay until Read=0 and Write=0 on an edge, then go to IDLE.
//     A level held past Done never triggers a second access.
//   Latency: request sampled at edge k; Done is high in the cycle after edge
//     k+1+WAIT_STATES.
//   Mdatain holds the last read result until the next completed read.
//   Reset mid-operation (WAIT/ACCESS before its edge): abort, no RAM write.
//     A write already committed at the ACCESS edge persists.
//   Done, Busy and Err are registered outputs; no combinational path from inputs.
// TESTING
//   1 WAIT_STATES=2: Write=1, Address=0x055, MDatain=0xDEADBEEF sampled at edge 0
//     -> Done high after edge 3 only. Then Read at 0x055 -> Mdatain=0xDEADBEEF with Done.
//   2 Hold Read=1 for 10 cycles after Done -> exactly one Done pulse.
//     Drop Read, re-raise -> second Done after 3 more edges.
//   3 Read=Write=1, Address=0x010 -> Done+Err pulse one cycle after sample.
//     A subsequent read of 0x010 returns the prior contents.
//   4 DEPTH=256, Write at Address=0x1FF -> Done+Err, no RAM change.
//     Read at 0x1FF -> Mdatain=0 with Err.
//   5 Write 0x12345678 to 0x020; assert Reset during WAIT -> all outputs 0 at once.
//     A read of 0x020 returns the old value.
//   6 WAIT_STATES=0: back-to-back read 0x001, read 0x002 with Read dropped for one cycle
//     between -> each Done one edge after its sample, correct data.

Source files
------------

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_if
// Purpose  : CU <-> memory responder handshake and data bus.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              Read;
  logic              Write;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] MDatain;
  logic [DATA_W-1:0] Mdatain;
  logic              Done;
  logic              Busy;
  logic              Err;

  modport master (
    output Read, Write, Address, MDatain,
    input  Mdatain, Done, Busy, Err
  );

  modport slave (
    input  Read, Write, Address, MDatain,
    output Mdatain, Done, Busy, Err
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Word RAM answering CU Read/Write strobes with wait states,
//            a one-cycle Done pulse and an Err pulse for illegal requests.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  wire logic      Clock,
  input  wire logic      Reset,
  mem_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam int              c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_depth     = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      c_wait_init = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                r_flag;
  logic                w_flag_nxt;
  logic                r_is_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_done;
  logic                r_busy;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_req_one;
  logic                w_req_both;
  logic                w_addr_oor;
  logic [c_idx_w-1:0]  w_idx;
  logic [DATA_W-1:0]   w_mem_q;

  assign w_req_one  = bus.Read ^ bus.Write;
  assign w_req_both = bus.Read & bus.Write;
  assign w_addr_oor = ({1'b0, bus.Address} >= c_depth);
  assign w_idx      = r_addr[c_idx_w-1:0];
  assign w_mem_q    = r_mem[w_idx];

  // Next-state logic; r_flag carries the error verdict from accept to DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_flag_nxt  = r_flag;
    case (r_state)
      S_IDLE: begin
        w_flag_nxt = 1'b0;
        if (w_req_both) begin
          w_state_nxt = S_DONE;
          w_flag_nxt  = 1'b1;
        end else if (w_req_one) begin
          w_flag_nxt = w_addr_oor;
          if (WAIT_STATES == 0) begin
            w_state_nxt = S_ACCESS;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_wait_init;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ACCESS: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (!bus.Read && !bus.Write) begin
          w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Done/Busy/Err are decoded from the next state so they stay registered.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_flag  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flag  <= w_flag_nxt;
      r_done  <= (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_err   <= (w_state_nxt == S_DONE) && w_flag_nxt;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      if (r_state == S_IDLE && w_req_one) begin
        r_is_write <= bus.Write;
        r_addr     <= bus.Address;
        r_wdata    <= bus.MDatain;
      end
      if (r_state == S_ACCESS && !r_is_write) begin
        r_rdata <= r_flag ? '0 : w_mem_q;
      end
    end
  end

  // RAM contents survive reset; out-of-range writes are dropped.
  always_ff @(posedge Clock) begin
    if (r_state == S_ACCESS && r_is_write && !r_flag) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign bus.Mdatain = r_rdata;
  assign bus.Done    = r_done;
  assign bus.Busy    = r_busy;
  assign bus.Err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed bench for mem_responder (WS=2, DEPTH=256, WS=0 variants).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        r_read;
  logic        r_write;
  logic [8:0]  r_addr;
  logic [31:0] r_wdata;
  int          sel;
  int          n_chk;
  int          n_fail;

  always #5 Clock = ~Clock;

  mem_responder_if #(.DATA_W(32), .ADDR_W(9)) bus_a ();
  mem_responder_if #(.DATA_W(32), .ADDR_W(9)) bus_b ();
  mem_responder_if #(.DATA_W(32), .ADDR_W(9)) bus_c ();

  assign bus_a.Read = r_read;  assign bus_a.Write = r_write;
  assign bus_a.Address = r_addr; assign bus_a.MDatain = r_wdata;
  assign bus_b.Read = r_read;  assign bus_b.Write = r_write;
  assign bus_b.Address = r_addr; assign bus_b.MDatain = r_wdata;
  assign bus_c.Read = r_read;  assign bus_c.Write = r_write;
  assign bus_c.Address = r_addr; assign bus_c.MDatain = r_wdata;

  mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(2)) u_a (
    .Clock(Clock), .Reset(Reset), .bus(bus_a));
  mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_STATES(2)) u_b (
    .Clock(Clock), .Reset(Reset), .bus(bus_b));
  mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(0)) u_c (
    .Clock(Clock), .Reset(Reset), .bus(bus_c));

  logic [31:0] obs_data;
  logic        obs_done;
  logic        obs_busy;
  logic        obs_err;

  always_comb begin
    obs_data = bus_a.Mdatain; obs_done = bus_a.Done;
    obs_busy = bus_a.Busy;    obs_err  = bus_a.Err;
    if (sel == 1) begin
      obs_data = bus_b.Mdatain; obs_done = bus_b.Done;
      obs_busy = bus_b.Busy;    obs_err  = bus_b.Err;
    end else if (sel == 2) begin
      obs_data = bus_c.Mdatain; obs_done = bus_c.Done;
      obs_busy = bus_c.Busy;    obs_err  = bus_c.Err;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Drives a request and returns the number of edges (sample edge included) until Done.
  task automatic request(input logic rd, input logic wr, input logic [8:0] a,
                         input logic [31:0] d, output int lat);
    r_read = rd; r_write = wr; r_addr = a; r_wdata = d;
    lat = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      lat++;
      if (obs_done === 1'b1) break;
    end
  endtask

  task automatic release_idle(input string tag);
    int n;
    r_read = 1'b0; r_write = 1'b0;
    n = 0;
    while (obs_busy !== 1'b0 && n < 16) begin
      tick();
      n++;
    end
    chk(tag, 32'(obs_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;
    n_chk = 0; n_fail = 0; sel = 0;
    Reset = 1'b1; r_read = 1'b0; r_write = 1'b0; r_addr = '0; r_wdata = '0;
    tick(); tick();
    chk("reset_done", 32'(obs_done), 32'd0);
    chk("reset_busy", 32'(obs_busy), 32'd0);
    chk("reset_err",  32'(obs_err),  32'd0);
    chk("reset_data", obs_data, 32'd0);
    Reset = 1'b0;
    tick();

    // 1: write then read back with two wait states
    request(1'b0, 1'b1, 9'h055, 32'hDEADBEEF, lat);
    chk("t1_wr_latency", 32'(lat), 32'd4);
    chk("t1_wr_err", 32'(obs_err), 32'd0);
    chk("t1_wr_data_unchanged", obs_data, 32'd0);
    release_idle("t1_wr_idle");
    request(1'b1, 1'b0, 9'h055, 32'h0, lat);
    chk("t1_rd_latency", 32'(lat), 32'd4);
    chk("t1_rd_data", obs_data, 32'hDEADBEEF);

    // 2: level held past Done gives no second access
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_done === 1'b1) pulses++;
    end
    chk("t2_extra_done_pulses", 32'(pulses), 32'd0);
    chk("t2_hold_busy", 32'(obs_busy), 32'd1);
    r_read = 1'b0;
    tick();
    chk("t2_idle_busy", 32'(obs_busy), 32'd0);
    request(1'b1, 1'b0, 9'h055, 32'h0, lat);
    chk("t2_second_latency", 32'(lat), 32'd4);
    chk("t2_second_data", obs_data, 32'hDEADBEEF);
    release_idle("t2_idle");

    // 3: simultaneous Read&Write is rejected without touching RAM
    request(1'b0, 1'b1, 9'h010, 32'hA5A50010, lat);
    release_idle("t3_pre_idle");
    request(1'b1, 1'b1, 9'h010, 32'hFFFFFFFF, lat);
    chk("t3_both_latency", 32'(lat), 32'd1);
    chk("t3_both_err", 32'(obs_err), 32'd1);
    release_idle("t3_both_idle");
    chk("t3_err_cleared", 32'(obs_err), 32'd0);
    request(1'b1, 1'b0, 9'h010, 32'h0, lat);
    chk("t3_rd_latency", 32'(lat), 32'd4);
    chk("t3_rd_data", obs_data, 32'hA5A50010);
    chk("t3_rd_err", 32'(obs_err), 32'd0);
    release_idle("t3_rd_idle");

    // 4: DEPTH=256 instance, out-of-range accesses
    sel = 1;
    request(1'b0, 1'b1, 9'h0FF, 32'h0BADF00D, lat);
    chk("t4_last_valid_err", 32'(obs_err), 32'd0);
    release_idle("t4_pre_idle");
    request(1'b0, 1'b1, 9'h1FF, 32'hCAFEF00D, lat);
    chk("t4_oor_wr_latency", 32'(lat), 32'd4);
    chk("t4_oor_wr_err", 32'(obs_err), 32'd1);
    release_idle("t4_oor_wr_idle");
    request(1'b1, 1'b0, 9'h0FF, 32'h0, lat);
    chk("t4_no_alias_data", obs_data, 32'h0BADF00D);
    release_idle("t4_alias_idle");
    request(1'b1, 1'b0, 9'h1FF, 32'h0, lat);
    chk("t4_oor_rd_data", obs_data, 32'd0);
    chk("t4_oor_rd_err", 32'(obs_err), 32'd1);
    release_idle("t4_oor_rd_idle");
    request(1'b1, 1'b0, 9'h100, 32'h0, lat);
    chk("t4_depth_edge_err", 32'(obs_err), 32'd1);
    release_idle("t4_edge_idle");

    // 5: reset during WAIT aborts the write
    sel = 0;
    request(1'b0, 1'b1, 9'h020, 32'h11111111, lat);
    release_idle("t5_pre_idle");
    request(1'b1, 1'b0, 9'h020, 32'h0, lat);
    chk("t5_old_data", obs_data, 32'h11111111);
    release_idle("t5_rd_idle");
    r_write = 1'b1; r_addr = 9'h020; r_wdata = 32'h12345678;
    tick();
    tick();
    chk("t5_inflight_busy", 32'(obs_busy), 32'd1);
    Reset = 1'b1;
    #1;
    chk("t5_rst_done", 32'(obs_done), 32'd0);
    chk("t5_rst_busy", 32'(obs_busy), 32'd0);
    chk("t5_rst_err",  32'(obs_err),  32'd0);
    chk("t5_rst_data", obs_data, 32'd0);
    r_write = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    request(1'b1, 1'b0, 9'h020, 32'h0, lat);
    chk("t5_after_rst_data", obs_data, 32'h11111111);
    release_idle("t5_after_idle");

    // 6: zero wait states, back-to-back reads with one low cycle between
    sel = 2;
    request(1'b0, 1'b1, 9'h001, 32'h00000A01, lat);
    chk("t6_wr_latency", 32'(lat), 32'd2);
    release_idle("t6_wr1_idle");
    request(1'b0, 1'b1, 9'h002, 32'h00000B02, lat);
    release_idle("t6_wr2_idle");
    request(1'b1, 1'b0, 9'h001, 32'h0, lat);
    chk("t6_rd1_latency", 32'(lat), 32'd2);
    chk("t6_rd1_data", obs_data, 32'h00000A01);
    tick();
    chk("t6_done_one_cycle", 32'(obs_done), 32'd0);
    r_read = 1'b0;
    tick();
    chk("t6_gap_busy", 32'(obs_busy), 32'd0);
    request(1'b1, 1'b0, 9'h002, 32'h0, lat);
    chk("t6_rd2_latency", 32'(lat), 32'd2);
    chk("t6_rd2_data", obs_data, 32'h00000B02);
    release_idle("t6_rd2_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
